// File: rtl/enc8b10b_pkg.sv
// 8b/10b code tables: the legal control bytes with both disparity columns,
// plus the data sub-block encoders shared by every lane.
package enc8b10b_pkg;

  localparam int N_K = 12;

  // K28.0..K28.7, K23.7, K27.7, K29.7, K30.7
  localparam logic [7:0] K_BYTE [N_K] = '{
    8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC,
    8'hF7, 8'hFB, 8'hFD, 8'hFE
  };

  localparam logic [9:0] K_CODE_N [N_K] = '{
    10'h0F4, 10'h0F9, 10'h0F5, 10'h0F3, 10'h0F2, 10'h0FA, 10'h0F6, 10'h0F8,
    10'h3A8, 10'h368, 10'h2E8, 10'h1E8
  };

  localparam logic [9:0] K_CODE_P [N_K] = '{
    10'h30B, 10'h306, 10'h30A, 10'h30C, 10'h30D, 10'h305, 10'h309, 10'h307,
    10'h057, 10'h097, 10'h117, 10'h217
  };

  function automatic int unsigned ones(input logic [9:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (v[i]) n++;
    end
    return n;
  endfunction

  // Returns abcdei; the RD+ column is the complement of the RD- column for
  // unbalanced codes and for D.7 (111000 -> 000111).
  function automatic logic [5:0] enc_5b6b(input logic [4:0] x, input logic rd);
    logic [5:0] c;
    c = '0;
    case (x)
      5'd0:  c = 6'b100111;
      5'd1:  c = 6'b011101;
      5'd2:  c = 6'b101101;
      5'd3:  c = 6'b110001;
      5'd4:  c = 6'b110101;
      5'd5:  c = 6'b101001;
      5'd6:  c = 6'b011001;
      5'd7:  c = 6'b111000;
      5'd8:  c = 6'b111001;
      5'd9:  c = 6'b100101;
      5'd10: c = 6'b010101;
      5'd11: c = 6'b110100;
      5'd12: c = 6'b001101;
      5'd13: c = 6'b101100;
      5'd14: c = 6'b011100;
      5'd15: c = 6'b010111;
      5'd16: c = 6'b011011;
      5'd17: c = 6'b100011;
      5'd18: c = 6'b010011;
      5'd19: c = 6'b110010;
      5'd20: c = 6'b001011;
      5'd21: c = 6'b101010;
      5'd22: c = 6'b011010;
      5'd23: c = 6'b111010;
      5'd24: c = 6'b110011;
      5'd25: c = 6'b100110;
      5'd26: c = 6'b010110;
      5'd27: c = 6'b110110;
      5'd28: c = 6'b001110;
      5'd29: c = 6'b101110;
      5'd30: c = 6'b011110;
      5'd31: c = 6'b101011;
    endcase
    if (rd && (ones({4'b0, c}) != 3 || c == 6'b111000)) c = ~c;
    return c;
  endfunction

  // Returns fghj; rd is the disparity after the 6b sub-block.
  function automatic logic [3:0] enc_3b4b(input logic [2:0] y, input logic alt7,
                                          input logic rd);
    logic [3:0] c;
    c = '0;
    case (y)
      3'd0: c = 4'b1011;
      3'd1: c = 4'b1001;
      3'd2: c = 4'b0101;
      3'd3: c = 4'b1100;
      3'd4: c = 4'b1101;
      3'd5: c = 4'b1010;
      3'd6: c = 4'b0110;
      3'd7: c = alt7 ? 4'b0111 : 4'b1110;
    endcase
    if (rd && (ones({6'b0, c}) != 2 || c == 4'b1100)) c = ~c;
    return c;
  endfunction

endpackage

// File: rtl/enc8b10b_byte.sv
// Combinational single-byte 8b/10b encoder: one link of the lane disparity chain.
module enc8b10b_byte
  import enc8b10b_pkg::*;
(
  input  logic [7:0] din,
  input  logic       k,
  input  logic       rd_in,
  output logic [9:0] code,
  output logic       rd_out,
  output logic       k_err
);

  logic [4:0] x;
  logic [2:0] y;
  logic [5:0] six;
  logic [3:0] four;
  logic       rd_mid;
  logic       alt7;
  logic       k_hit;
  logic [9:0] k_code;

  assign x = din[4:0];
  assign y = din[7:5];

  always_comb begin
    k_hit  = 1'b0;
    k_code = '0;
    for (int i = 0; i < N_K; i++) begin
      if (din == K_BYTE[i]) begin
        k_hit  = 1'b1;
        k_code = rd_in ? K_CODE_P[i] : K_CODE_N[i];
      end
    end
  end

  always_comb begin
    six    = enc_5b6b(x, rd_in);
    rd_mid = (ones({4'b0, six}) == 3) ? rd_in : ~rd_in;
    // A7 avoids a run of five equal bits across the 6b/4b boundary
    alt7   = (y == 3'd7) &&
             (rd_mid ? (x == 5'd11 || x == 5'd13 || x == 5'd14)
                     : (x == 5'd17 || x == 5'd18 || x == 5'd20));
    four   = enc_3b4b(y, alt7, rd_mid);

    code   = '0;
    rd_out = rd_in;
    k_err  = 1'b0;
    if (k) begin
      if (k_hit) begin
        code   = k_code;
        rd_out = (ones(k_code) == 5) ? rd_in : ~rd_in;
      end else begin
        k_err  = 1'b1;
      end
    end else begin
      code   = {six, four};
      rd_out = (ones({6'b0, four}) == 2) ? rd_mid : ~rd_mid;
    end
  end

endmodule

// File: rtl/enc8b10b_multilane.sv
// LANES-wide 8b/10b encoder with a running-disparity chain across lanes,
// one-cycle latency and a saturating illegal-K counter.
module enc8b10b_multilane
  import enc8b10b_pkg::*;
#(
  parameter int LANES   = 4,
  parameter bit INIT_RD = 1'b0,
  parameter int CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_valid,
  input  logic [8*LANES-1:0]    i_data,
  input  logic [LANES-1:0]      i_k,
  input  logic                  i_rd_clr,
  output logic                  o_valid,
  output logic [10*LANES-1:0]   o_data,
  output logic [LANES-1:0]      o_k_error,
  output logic                  o_rd,
  output logic [CNT_W-1:0]      o_kerr_cnt
);

  // Handshake: i_valid qualifies i_data/i_k for exactly one cycle; there is no
  // backpressure, every valid word is accepted and appears one cycle later
  // with o_valid high. Outputs hold their last word while o_valid is low.

  logic                rd_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [LANES:0]      rd_chain;
  logic [10*LANES-1:0] codes;
  logic [LANES-1:0]    k_errs;
  logic [3:0]          err_cnt;
  logic [CNT_W-1:0]    cnt_base;
  logic [CNT_W+3:0]    cnt_sum;
  logic [CNT_W-1:0]    cnt_next;

  assign rd_chain[0] = i_rd_clr ? INIT_RD : rd_q;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    enc8b10b_byte u_byte (
      .din    (i_data[8*g +: 8]),
      .k      (i_k[g]),
      .rd_in  (rd_chain[g]),
      .code   (codes[10*g +: 10]),
      .rd_out (rd_chain[g+1]),
      .k_err  (k_errs[g])
    );
  end

  always_comb begin
    err_cnt = '0;
    for (int n = 0; n < LANES; n++) begin
      err_cnt = err_cnt + {3'b0, k_errs[n]};
    end
    cnt_base = i_rd_clr ? '0 : cnt_q;
    cnt_sum  = {4'b0, cnt_base} + {{CNT_W{1'b0}}, err_cnt};
    cnt_next = (|cnt_sum[CNT_W+3:CNT_W]) ? '1 : cnt_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid   <= 1'b0;
      o_data    <= '0;
      o_k_error <= '0;
      rd_q      <= INIT_RD;
      cnt_q     <= '0;
    end else begin
      o_valid <= i_valid;
      if (i_valid) begin
        o_data    <= codes;
        o_k_error <= k_errs;
        rd_q      <= rd_chain[LANES];
        cnt_q     <= cnt_next;
      end else if (i_rd_clr) begin
        rd_q  <= INIT_RD;
        cnt_q <= '0;
      end
    end
  end

  assign o_rd       = rd_q;
  assign o_kerr_cnt = cnt_q;

endmodule

// File: tb/tb_enc8b10b_multilane.sv
// Bench for enc8b10b_multilane: a 4-lane instance against a table-driven
// reference model, and a 1-lane CNT_W=2 instance for directed corner cases.
module tb_enc8b10b_multilane;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // 4-lane DUT
  logic        i_valid, i_rd_clr;
  logic [31:0] i_data;
  logic [3:0]  i_k;
  logic        o_valid, o_rd;
  logic [39:0] o_data;
  logic [3:0]  o_k_error;
  logic [15:0] o_kerr_cnt;

  // 1-lane, 2-bit counter DUT
  logic        s_valid, s_clr, s_o_valid, s_o_rd;
  logic [7:0]  s_data;
  logic [0:0]  s_k, s_o_kerr;
  logic [9:0]  s_o_data;
  logic [1:0]  s_o_cnt;

  enc8b10b_multilane #(.LANES(4), .INIT_RD(1'b0), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_data(i_data), .i_k(i_k),
    .i_rd_clr(i_rd_clr), .o_valid(o_valid), .o_data(o_data),
    .o_k_error(o_k_error), .o_rd(o_rd), .o_kerr_cnt(o_kerr_cnt)
  );

  enc8b10b_multilane #(.LANES(1), .INIT_RD(1'b0), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .i_valid(s_valid), .i_data(s_data), .i_k(s_k),
    .i_rd_clr(s_clr), .o_valid(s_o_valid), .o_data(s_o_data),
    .o_k_error(s_o_kerr), .o_rd(s_o_rd), .o_kerr_cnt(s_o_cnt)
  );

  // ---------------- reference tables (abcdei / fghj, both RD columns) ----------------
  logic [5:0] t6n [32] = '{
    6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
    6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
    6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
    6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011
  };
  logic [5:0] t6p [32] = '{
    6'b011000, 6'b100010, 6'b010010, 6'b110001, 6'b001010, 6'b101001, 6'b011001, 6'b000111,
    6'b000110, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b101000,
    6'b100100, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b000101,
    6'b001100, 6'b100110, 6'b010110, 6'b001001, 6'b001110, 6'b010001, 6'b100001, 6'b010100
  };
  logic [3:0] t4n [8] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
  logic [3:0] t4p [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b0001};
  logic [3:0] k4n [8] = '{4'b1011, 4'b0110, 4'b1010, 4'b1100, 4'b1101, 4'b0101, 4'b1001, 4'b0111};
  logic [3:0] k4p [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b1000};
  logic [7:0] legal_k [12] = '{8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC,
                               8'hF7, 8'hFB, 8'hFD, 8'hFE};

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [61:0] exp_q[$];   // {valid, data[39:0], kerr[3:0], rd, cnt[15:0]}
  logic        m_rd;
  logic [15:0] m_cnt;
  logic [39:0] m_data;
  logic [3:0]  m_kerr;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void enc_ref(input logic [7:0] b, input logic k, input logic rd,
                                  output logic [9:0] code, output logic rd_o,
                                  output logic err);
    int x, y, d;
    logic [5:0] s;
    logic [3:0] f;
    logic r;
    x = int'(b[4:0]);
    y = int'(b[7:5]);
    if (k && !(x == 28 || (y == 7 && (x == 23 || x == 27 || x == 29 || x == 30)))) begin
      code = '0; rd_o = rd; err = 1'b1;
      return;
    end
    err = 1'b0;
    if (k && x == 28) s = rd ? 6'b110000 : 6'b001111;
    else              s = rd ? t6p[x] : t6n[x];
    d = 2 * $countones(s) - 6;
    r = (d > 0) ? 1'b1 : (d < 0) ? 1'b0 : rd;
    if (k) f = r ? k4p[y] : k4n[y];
    else if (y == 7 && ((!r && (x == 17 || x == 18 || x == 20)) ||
                        ( r && (x == 11 || x == 13 || x == 14))))
      f = r ? 4'b1000 : 4'b0111;
    else f = r ? t4p[y] : t4n[y];
    d = 2 * $countones(f) - 4;
    rd_o = (d > 0) ? 1'b1 : (d < 0) ? 1'b0 : r;
    code = {s, f};
  endfunction

  task automatic model_reset();
    m_rd = 1'b0; m_cnt = '0; m_data = '0; m_kerr = '0;
  endtask

  task automatic model_step(input logic v, input logic [31:0] d, input logic [3:0] k,
                            input logic clr);
    logic rd, ro, er;
    logic [9:0] c;
    int total;
    if (v) begin
      rd = clr ? 1'b0 : m_rd;
      total = clr ? 0 : int'(m_cnt);
      for (int n = 0; n < 4; n++) begin
        enc_ref(d[8*n +: 8], k[n], rd, c, ro, er);
        m_data[10*n +: 10] = c;
        m_kerr[n] = er;
        rd = ro;
        if (er) total++;
      end
      m_rd  = rd;
      m_cnt = (total > 65535) ? 16'hFFFF : 16'(total);
    end else if (clr) begin
      m_rd = 1'b0; m_cnt = '0;
    end
  endtask

  // ---------------- drivers ----------------
  task automatic drive(input logic v, input logic [31:0] d, input logic [3:0] k,
                       input logic clr);
    @(negedge clk);
    i_valid = v; i_data = d; i_k = k; i_rd_clr = clr;
    model_step(v, d, k, clr);
    exp_q.push_back({v, m_data, m_kerr, m_rd, m_cnt});
  endtask

  task automatic sat_step(input logic v, input logic [7:0] d, input logic k,
                          input logic clr);
    @(negedge clk);
    s_valid = v; s_data = d; s_k = k; s_clr = clr;
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    logic [61:0] e;
    #1;
    if (rst_n && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("mon_valid", 64'(o_valid),    64'(e[61]));
      check("mon_data",  64'(o_data),     64'(e[60:21]));
      check("mon_kerr",  64'(o_k_error),  64'(e[20:17]));
      check("mon_rd",    64'(o_rd),       64'(e[16]));
      check("mon_cnt",   64'(o_kerr_cnt), 64'(e[15:0]));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] d;
    logic [3:0]  k;
    rst_n = 1'b0;
    i_valid = 0; i_data = '0; i_k = '0; i_rd_clr = 0;
    s_valid = 0; s_data = '0; s_k = '0; s_clr = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    check("rst_valid", 64'(o_valid), 64'd0);
    check("rst_data",  64'(o_data), 64'd0);
    check("rst_kerr",  64'(o_k_error), 64'd0);
    check("rst_rd",    64'(o_rd), 64'd0);
    check("rst_cnt",   64'(o_kerr_cnt), 64'd0);
    check("rst_s_data", 64'(s_o_data), 64'd0);
    @(negedge clk) rst_n = 1'b1;

    // 1-lane directed
    sat_step(1, 8'hBC, 1, 0);
    check("k285_a_data", 64'(s_o_data), 64'h0FA);
    check("k285_a_rd",   64'(s_o_rd), 64'd1);
    check("k285_a_vld",  64'(s_o_valid), 64'd1);
    sat_step(1, 8'hBC, 1, 0);
    check("k285_b_data", 64'(s_o_data), 64'h305);
    check("k285_b_rd",   64'(s_o_rd), 64'd0);
    sat_step(1, 8'h00, 0, 0);
    check("d00_neg_data", 64'(s_o_data), 64'h274);
    check("d00_neg_rd",   64'(s_o_rd), 64'd0);
    sat_step(1, 8'hBC, 1, 0);
    sat_step(1, 8'h00, 0, 0);
    check("d00_pos_data", 64'(s_o_data), 64'h18B);
    check("d00_pos_rd",   64'(s_o_rd), 64'd1);
    for (int i = 1; i <= 4; i++) begin
      sat_step(1, 8'h00, 1, 0);
      check("sat_data", 64'(s_o_data), 64'd0);
      check("sat_kerr", 64'(s_o_kerr), 64'd1);
      check("sat_rd",   64'(s_o_rd), 64'd1);
      check("sat_cnt",  64'(s_o_cnt), (i > 3) ? 64'd3 : 64'(i));
    end
    sat_step(0, 8'hBC, 1, 0);
    check("idle_valid", 64'(s_o_valid), 64'd0);
    check("idle_hold",  64'(s_o_data), 64'd0);
    check("idle_cnt",   64'(s_o_cnt), 64'd3);
    sat_step(1, 8'h00, 1, 1);
    check("clr_v_cnt", 64'(s_o_cnt), 64'd1);
    check("clr_v_rd",  64'(s_o_rd), 64'd0);
    sat_step(1, 8'hBC, 1, 0);
    check("clr_v_k285", 64'(s_o_data), 64'h0FA);
    sat_step(0, 8'h00, 0, 1);
    check("clr_i_rd",  64'(s_o_rd), 64'd0);
    check("clr_i_cnt", 64'(s_o_cnt), 64'd0);
    sat_step(0, 8'h00, 0, 0);

    // 4-lane directed, also tracked by the scoreboard
    drive(1, 32'h00BC00BC, 4'b0101, 1);
    settle();
    check("mix_data", 64'(o_data), 64'({10'h274, 10'h305, 10'h18B, 10'h0FA}));
    check("mix_rd",   64'(o_rd), 64'd0);
    drive(1, 32'hB5B5B5B5, 4'b0000, 0);
    settle();
    check("d215_data", 64'(o_data), 64'({4{10'h2AA}}));
    check("d215_rd",   64'(o_rd), 64'd0);
    drive(1, 32'hB5B5B5BC, 4'b0001, 0);
    settle();
    check("d215_pos_data", 64'(o_data), 64'({10'h2AA, 10'h2AA, 10'h2AA, 10'h0FA}));
    check("d215_pos_rd",   64'(o_rd), 64'd1);
    drive(1, 32'h00000000, 4'b0010, 1);
    settle();
    check("badk_data", 64'(o_data), 64'({10'h274, 10'h274, 10'h000, 10'h274}));
    check("badk_kerr", 64'(o_k_error), 64'b0010);
    check("badk_cnt",  64'(o_kerr_cnt), 64'd1);

    // randomized traffic
    for (int t = 0; t < 400; t++) begin
      for (int n = 0; n < 4; n++) begin
        if ($urandom_range(0, 3) == 0) begin
          k[n] = 1'b1;
          d[8*n +: 8] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                                    : legal_k[$urandom_range(0, 11)];
        end else begin
          k[n] = 1'b0;
          d[8*n +: 8] = 8'($urandom_range(0, 255));
        end
      end
      drive(($urandom_range(0, 4) != 0), d, k, ($urandom_range(0, 15) == 0));
    end

    // reset in the middle of a valid stream
    @(negedge clk);
    i_valid = 1; i_data = 32'h12345678; i_k = 4'b0000; i_rd_clr = 0;
    #2 rst_n = 1'b0;
    exp_q.delete();
    model_reset();
    @(negedge clk);
    i_data = 32'h000000BC; i_k = 4'b0001;
    settle();
    check("midrst_valid", 64'(o_valid), 64'd0);
    check("midrst_data",  64'(o_data), 64'd0);
    check("midrst_rd",    64'(o_rd), 64'd0);
    check("midrst_cnt",   64'(o_kerr_cnt), 64'd0);
    @(negedge clk);
    i_valid = 0;
    rst_n = 1'b1;
    drive(1, 32'h000000BC, 4'b0001, 0);
    settle();
    check("post_rst_k285", 64'(o_data[9:0]), 64'h0FA);
    drive(1, 32'h00000000, 4'b1111, 0);
    drive(0, 32'h0, 4'b0000, 1);
    settle();
    check("clr_idle_rd",  64'(o_rd), 64'd0);
    check("clr_idle_cnt", 64'(o_kerr_cnt), 64'd0);
    drive(0, 32'h0, 4'b0000, 0);
    settle();
    settle();
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
